// File: rtl/lif_mon_pkg.sv
// Shared constants for the LIF spike-rate monitor: default widths and FSM state codes.
// Optional feature macro used by this slice: LIF_MON_FIRST_SPIKE_EN.
package lif_mon_pkg;

    localparam int unsigned NUM_CH_DEF = 4;
    localparam int unsigned CNT_W_DEF  = 8;
    localparam int unsigned WIN_W_DEF  = 8;

    // Saturation ceiling of a default-width channel count
    localparam logic [CNT_W_DEF-1:0] CNT_MAX_DEF = '1;

    // FSM state encoding
    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_COUNT = 1'b1;

endpackage

// File: rtl/lif_spike_counter.sv
// Per-channel saturating spike accumulator with synchronous clear.
// With LIF_MON_FIRST_SPIKE_EN defined it also captures the window index of the first spike.
module lif_spike_counter
    import lif_mon_pkg::*;
#(
    parameter int unsigned CNT_W = CNT_W_DEF
`ifdef LIF_MON_FIRST_SPIKE_EN
    , parameter int unsigned WIN_W = WIN_W_DEF
`endif
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic             en,
    input  logic             spike,
`ifdef LIF_MON_FIRST_SPIKE_EN
    input  logic [WIN_W-1:0] win_idx,
    output logic [WIN_W-1:0] first_next,
`endif
    output logic [CNT_W-1:0] count_next
);

    localparam logic [CNT_W-1:0] SAT = '1;

    logic [CNT_W-1:0] acc_q;

    // Count including this cycle's spike; holds at the ceiling instead of wrapping
    always_comb begin
        count_next = acc_q;
        if (en && spike && (acc_q != SAT)) begin
            count_next = acc_q + CNT_W'(1);
        end
    end

    // Accumulator state; clear wins over accumulation
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            acc_q <= '0;
        end else if (clear) begin
            acc_q <= '0;
        end else begin
            acc_q <= count_next;
        end
    end

`ifdef LIF_MON_FIRST_SPIKE_EN
    logic             seen_q;
    logic [WIN_W-1:0] first_q;

    // First-spike index including this cycle; all-ones means no spike yet
    always_comb begin
        first_next = first_q;
        if (en && spike && !seen_q) begin
            first_next = win_idx;
        end
    end

    // First-spike capture state
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            seen_q  <= 1'b0;
            first_q <= '1;
        end else if (clear) begin
            seen_q  <= 1'b0;
            first_q <= '1;
        end else begin
            seen_q  <= seen_q | (en & spike);
            first_q <= first_next;
        end
    end
`endif

endmodule

// File: rtl/lif_spike_rate_monitor.sv
// Windowed spike-rate monitor: counts spikes per channel over win_len cycles, latches the
// counts at window end and offers them on a valid/ready port. Unconsumed results cause the
// next one to be dropped and the sticky overrun flag to set.
// Optional feature macro: LIF_MON_FIRST_SPIKE_EN (adds first_lat output).
module lif_spike_rate_monitor
    import lif_mon_pkg::*;
#(
    parameter int unsigned NUM_CH = NUM_CH_DEF,
    parameter int unsigned CNT_W  = CNT_W_DEF,
    parameter int unsigned WIN_W  = WIN_W_DEF
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [NUM_CH-1:0]       spike_in,
    input  logic                    enable,
    input  logic [WIN_W-1:0]        win_len,
    output logic [NUM_CH*CNT_W-1:0] count_out,
    output logic                    count_valid,
    input  logic                    count_ready,
    output logic                    busy,
    output logic                    overrun
`ifdef LIF_MON_FIRST_SPIKE_EN
    ,
    output logic [NUM_CH*WIN_W-1:0] first_lat
`endif
);

    logic [0:0]               state_q, state_d;
    logic [WIN_W-1:0]         win_cnt_q, win_cnt_d;
    logic [WIN_W-1:0]         win_load;
    logic                     acc_clear, acc_en;
    logic                     last_cycle, slot_free;
    logic [NUM_CH*CNT_W-1:0]  count_next;
    logic [NUM_CH*CNT_W-1:0]  count_out_q, count_out_d;
    logic                     count_valid_q, count_valid_d;
    logic                     overrun_q, overrun_d;

    // Zero-length windows run as one cycle
    assign win_load   = (win_len == '0) ? WIN_W'(1) : win_len;
    assign last_cycle = (state_q == ST_COUNT) && (win_cnt_q == WIN_W'(1));
    assign slot_free  = !count_valid_q || count_ready;

    // Window sequencing: load on start, decrement, reload back-to-back or stop/abort
    always_comb begin
        state_d   = state_q;
        win_cnt_d = win_cnt_q;
        acc_clear = 1'b0;
        acc_en    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (enable) begin
                    state_d   = ST_COUNT;
                    win_cnt_d = win_load;
                    acc_clear = 1'b1;
                end
            end
            default: begin
                acc_en = 1'b1;
                if (last_cycle) begin
                    // The last cycle always yields a result; enable only picks what follows
                    acc_clear = 1'b1;
                    if (enable) begin
                        win_cnt_d = win_load;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else if (!enable) begin
                    acc_clear = 1'b1;
                    state_d   = ST_IDLE;
                end else begin
                    win_cnt_d = win_cnt_q - WIN_W'(1);
                end
            end
        endcase
    end

    // Output slot: load on window end if free, otherwise flag the drop
    always_comb begin
        count_out_d   = count_out_q;
        count_valid_d = count_valid_q && !count_ready;
        overrun_d     = overrun_q;
        if (last_cycle) begin
            if (slot_free) begin
                count_out_d   = count_next;
                count_valid_d = 1'b1;
            end else begin
                overrun_d = 1'b1;
            end
        end
    end

    // Control and output registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= ST_IDLE;
            win_cnt_q     <= '0;
            count_out_q   <= '0;
            count_valid_q <= 1'b0;
            overrun_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            win_cnt_q     <= win_cnt_d;
            count_out_q   <= count_out_d;
            count_valid_q <= count_valid_d;
            overrun_q     <= overrun_d;
        end
    end

    assign count_out   = count_out_q;
    assign count_valid = count_valid_q;
    assign overrun     = overrun_q;
    assign busy        = (state_q == ST_COUNT);

`ifdef LIF_MON_FIRST_SPIKE_EN
    logic [WIN_W-1:0]         win_idx_q;
    logic [NUM_CH*WIN_W-1:0]  first_next;
    logic [NUM_CH*WIN_W-1:0]  first_lat_q;

    // 0-based cycle index within the current window
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            win_idx_q <= '0;
        end else if (acc_clear) begin
            win_idx_q <= '0;
        end else if (acc_en) begin
            win_idx_q <= win_idx_q + WIN_W'(1);
        end
    end

    // First-spike latencies share the count slot's load condition
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            first_lat_q <= '0;
        end else if (last_cycle && slot_free) begin
            first_lat_q <= first_next;
        end
    end

    assign first_lat = first_lat_q;
`endif

    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        lif_spike_counter #(
            .CNT_W(CNT_W)
`ifdef LIF_MON_FIRST_SPIKE_EN
            , .WIN_W(WIN_W)
`endif
        ) u_cnt (
            .clk       (clk),
            .reset     (reset),
            .clear     (acc_clear),
            .en        (acc_en),
            .spike     (spike_in[c]),
`ifdef LIF_MON_FIRST_SPIKE_EN
            .win_idx   (win_idx_q),
            .first_next(first_next[c*WIN_W +: WIN_W]),
`endif
            .count_next(count_next[c*CNT_W +: CNT_W])
        );
    end

endmodule

// File: doc/lif_spike_rate_monitor.md
Name: lif_spike_rate_monitor

Overview:
- Downstream consumer of the LIF neuron network's spike outputs: the three hidden-neuron spikes plus the final spike.
- Counts spikes per channel over a programmable window of clock cycles.
- Latches each channel's count at window end and presents the set through a valid/ready handshake.
- Gives a host-side readout, or a later decode stage, rate-coded network activity without sampling every cycle.

Parameters:
NUM_CH, 4, number of spike channels monitored
CNT_W, 8, per-channel count width (saturating)
WIN_W, 8, window-length register width

Ports:
clk  input  1  single system clock; all state on rising edge
reset  input  1  asynchronous, active-high reset
spike_in  input  NUM_CH  spike lines; bit0=final spike, bit1..3=neurons 1..3; one-cycle pulses or levels, sampled every cycle
enable  input  1  level; high = run windows continuously, low = abort/idle
win_len  input  WIN_W  window length in cycles; sampled only at window start; 0 treated as 1
count_out  output  NUM_CH*CNT_W  latched counts, channel c at [c*CNT_W +: CNT_W]
count_valid  output  1  count_out holds an unconsumed result
count_ready  input  1  consumer accepts result when count_valid&&count_ready
busy  output  1  high while a window is in progress
overrun  output  1  sticky; a completed window was dropped because the previous result was unconsumed

Behaviour:
- Reset (async, any time): FSM=IDLE; accumulators, window counter, count_out = 0; count_valid=0, busy=0, overrun=0.
- FSM states: IDLE, COUNT.
- IDLE: busy=0. If enable=1, load win_cnt = (win_len==0 ? 1 : win_len), clear accumulators, go COUNT next cycle. spike_in ignored in IDLE.
- COUNT: busy=1. Each cycle, per channel: acc[c] += spike_in[c], saturating at 2^CNT_W-1 (no wrap). win_cnt decrements each cycle.
- Last window cycle (win_cnt==1): that cycle's spikes are included in the result.
  - If the output slot is free (count_valid=0, or a handshake completes this same cycle): count_out <= final counts; count_valid=1 on the next cycle.
  - Otherwise: result dropped, count_out unchanged, overrun <= 1.
- After the last cycle: if enable=1, reload win_cnt from win_len and clear accumulators in the same edge. Windows run back-to-back with no gap cycle; FSM stays in COUNT. If enable=0, go to IDLE.
- enable falls mid-window: next edge aborts the window, clears accumulators, goes to IDLE, produces no result, leaves overrun unchanged. Any pending count_valid/count_out remains until consumed.
- Handshake: count_valid stays high, and count_out stable, until count_valid&&count_ready. The cycle after acceptance: count_valid=0, unless a new result is loaded in that same cycle, in which case it stays 1 with the new data.
- Latency: the last window spike appears in count_out 1 cycle after that spike's cycle.
- overrun clears only on reset.

Optional Feature:
LIF_MON_FIRST_SPIKE_EN
- Defined:
  - Adds output first_lat (NUM_CH*WIN_W): per channel, the window cycle index (0-based) of the first spike, latched alongside count_out under the same count_valid.
  - Channels with no spike report all-ones.
  - Latency counters obey the same reset, abort and overrun rules as the counts.
- Undefined: port and logic are absent; all other behaviour is identical.

Decomposition:
- Package lif_mon_pkg: FSM state enum (IDLE, COUNT), default widths NUM_CH/CNT_W/WIN_W, saturating max constant.
- One sub-module: lif_spike_counter, a per-channel saturating accumulator with clear and enable (plus first-spike capture when the macro is defined). Instantiated NUM_CH times by generate.

Test Plan:
- Reset mid-window: win_len=10, spikes on bit0 every cycle, assert reset at cycle 5 -> all outputs 0 immediately (async); after release with enable=1, the next full window gives count_out[7:0]=10.
- Basic count: win_len=8, bit1 pulsed on 3 cycles, bit3 on 8 cycles, count_ready=1 -> one valid pulse; ch0=0, ch1=3, ch2=0, ch3=8; valid exactly 1 cycle after the window's 8th cycle.
- Saturation and zero length: win_len=0 (spike on bit2) -> window of 1 cycle, ch2=1. Then win_len=255, CNT_W=4 build, bit2 constantly high -> ch2=15, no wrap.
- Back-to-back and overrun: win_len=4, enable held, count_ready=0 -> first result held stable; second window completes with overrun=1 and count_out still showing window 1; raise count_ready -> accepted, valid drops, third window result loads normally.
- Abort: win_len=20, enable dropped at cycle 7 -> FSM to IDLE, busy=0, no count_valid, overrun=0; re-enable -> fresh window counts from 0.
- LIF_MON_FIRST_SPIKE_EN build: win_len=16, bit0 first spikes at window cycle 5, bit1 never spikes -> first_lat ch0=5, ch1=8'hFF.
